// File: rtl/pslip_iter_ctrl.sv
`timescale 1ns/1ps
// pslip_iter_ctrl: iterative pSLIP match scheduler for one switch time slot.
// Starts the priority-select stage, captures its request matrix, then runs
// request-grant-accept iterations with round-robin grant/accept pointers.
// The result is a conflict-free N x N match matrix.
//
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   slot_start   - start-of-slot pulse (dropped while busy)
//   sel_update   - one-cycle pulse asking the selector for new requests
//   sel_ready    - selector result valid pulse; sel_req sampled then
//   sel_req      - request matrix, bit i*N+j = input i wants output j
//   match        - match matrix, bit i*N+j = input i connected to output j
//   match_valid  - one-cycle pulse, match is final this cycle
//   busy         - slot in progress (acceptance through match_valid)
//   timeout_err  - one-cycle pulse when the selector never answered
//
// Build option: define PSLIP_EARLY_EXIT_EN to finish as soon as an
// iteration adds no new pair (same match and pointers, shorter latency).
module pslip_iter_ctrl #(
    parameter int unsigned N    = 16,
    parameter int unsigned ITER = 4,
    parameter int unsigned TO   = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slot_start,
    output logic             sel_update,
    input  logic             sel_ready,
    input  logic [N*N-1:0]   sel_req,
    output logic [N*N-1:0]   match,
    output logic             match_valid,
    output logic             busy,
    output logic             timeout_err
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(TO + 1);
    localparam int unsigned TW = $clog2(ITER + 1);

    typedef enum logic [2:0] {IDLE, WAIT_SEL, GRANT, ACCEPT, DONE} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [TW-1:0]   iter, iter_d;
    logic [N*N-1:0]  req_r, req_d;
    logic [N*N-1:0]  match_d;
    logic [N-1:0]    matched_in, matched_in_d;
    logic [N-1:0]    matched_out, matched_out_d;
    logic [IW-1:0]   g_ptr [N];
    logic [IW-1:0]   g_ptr_d [N];
    logic [IW-1:0]   a_ptr [N];
    logic [IW-1:0]   a_ptr_d [N];
    logic [IW-1:0]   gnt [N];
    logic [IW-1:0]   gnt_d [N];
    logic [N-1:0]    gnt_v, gnt_v_d;
    logic [IW-1:0]   gnt_sel [N];
    logic [N-1:0]    gnt_sel_v;
    logic [IW-1:0]   acc_j [N];
    logic [N-1:0]    acc_v;
    logic            sel_update_d, match_valid_d, busy_d, timeout_err_d;
    logic            last_iter;

    // (base + k) mod N without a divider
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    // Grant: each unmatched output picks the first requesting unmatched input at/after g_ptr
    always_comb begin : grant_search
        logic          found;
        logic [IW-1:0] idx;
        found     = 1'b0;
        idx       = '0;
        gnt_sel   = '{default: '0};
        gnt_sel_v = '0;
        for (int unsigned j = 0; j < N; j++) begin
            found = 1'b0;
            for (int unsigned k = 0; k < N; k++) begin
                idx = wrap_add(g_ptr[j], k);
                if (!found && !matched_out[j] && !matched_in[idx] && req_r[32'(idx)*N + j]) begin
                    found      = 1'b1;
                    gnt_sel[j] = idx;
                end
            end
            gnt_sel_v[j] = found;
        end
    end

    // Accept: each unmatched input picks the first granting output at/after a_ptr
    always_comb begin : accept_search
        logic          found;
        logic [IW-1:0] idx;
        found = 1'b0;
        idx   = '0;
        acc_j = '{default: '0};
        acc_v = '0;
        for (int unsigned i = 0; i < N; i++) begin
            found = 1'b0;
            for (int unsigned k = 0; k < N; k++) begin
                idx = wrap_add(a_ptr[i], k);
                if (!found && !matched_in[i] && gnt_v[idx] && (gnt[idx] == IW'(i))) begin
                    found    = 1'b1;
                    acc_j[i] = idx;
                end
            end
            acc_v[i] = found;
        end
    end

`ifdef PSLIP_EARLY_EXIT_EN
    assign last_iter = (iter == TW'(ITER - 1)) || (acc_v == '0);
`else
    assign last_iter = (iter == TW'(ITER - 1));
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        iter_d        = iter;
        req_d         = req_r;
        match_d       = match;
        matched_in_d  = matched_in;
        matched_out_d = matched_out;
        g_ptr_d       = g_ptr;
        a_ptr_d       = a_ptr;
        gnt_d         = gnt;
        gnt_v_d       = gnt_v;
        sel_update_d  = 1'b0;
        match_valid_d = 1'b0;
        timeout_err_d = 1'b0;
        busy_d        = busy;

        case (state)
            IDLE: begin
                cnt_d = '0;
                if (slot_start) begin
                    sel_update_d = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = WAIT_SEL;
                end
            end
            WAIT_SEL: begin
                if (sel_ready) begin
                    req_d         = sel_req;
                    match_d       = '0;
                    matched_in_d  = '0;
                    matched_out_d = '0;
                    iter_d        = '0;
                    state_d       = GRANT;
                end else if (cnt == CW'(TO - 1)) begin
                    timeout_err_d = 1'b1;
                    busy_d        = 1'b0;
                    cnt_d         = '0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            GRANT: begin
                gnt_d   = gnt_sel;
                gnt_v_d = gnt_sel_v;
                state_d = ACCEPT;
            end
            ACCEPT: begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (acc_v[i]) begin
                        match_d[i*N + 32'(acc_j[i])] = 1'b1;
                        matched_in_d[i]              = 1'b1;
                        matched_out_d[acc_j[i]]      = 1'b1;
                        // pointers only move on first-iteration matches (avoids starvation)
                        if (iter == '0) begin
                            g_ptr_d[acc_j[i]] = wrap_add(IW'(i), 1);
                            a_ptr_d[i]        = wrap_add(acc_j[i], 1);
                        end
                    end
                end
                iter_d = iter + TW'(1);
                if (last_iter) begin
                    match_valid_d = 1'b1;
                    state_d       = DONE;
                end else begin
                    state_d = GRANT;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            iter        <= '0;
            req_r       <= '0;
            match       <= '0;
            matched_in  <= '0;
            matched_out <= '0;
            gnt_v       <= '0;
            sel_update  <= 1'b0;
            match_valid <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            for (int unsigned k = 0; k < N; k++) begin
                g_ptr[k] <= '0;
                a_ptr[k] <= '0;
                gnt[k]   <= '0;
            end
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            iter        <= iter_d;
            req_r       <= req_d;
            match       <= match_d;
            matched_in  <= matched_in_d;
            matched_out <= matched_out_d;
            gnt_v       <= gnt_v_d;
            sel_update  <= sel_update_d;
            match_valid <= match_valid_d;
            busy        <= busy_d;
            timeout_err <= timeout_err_d;
            g_ptr       <= g_ptr_d;
            a_ptr       <= a_ptr_d;
            gnt         <= gnt_d;
        end
    end

endmodule
